// File: rtl/poly_fir_mac_sched.sv
// Issue sequencer for a resource-shared polyphase decimating FIR: circular sample buffer
// writes plus one TAP_LEN-long MAC burst per DECIMATION_FACTOR input samples.
module poly_fir_mac_sched #(
  parameter int unsigned DECIMATION_FACTOR = 9,
  parameter int unsigned SUB_TAP_LEN       = 7,
  parameter int unsigned BUF_AW            = 7,
  parameter int unsigned MAC_LATENCY       = 2
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                flush,
  input  logic                                                din_valid,
  output logic                                                smp_we,
  output logic [BUF_AW-1:0]                                   smp_waddr,
  output logic [BUF_AW-1:0]                                   smp_raddr,
  output logic [$clog2(DECIMATION_FACTOR*SUB_TAP_LEN)-1:0]    coef_addr,
  output logic                                                mac_en,
  output logic                                                acc_clr,
  output logic                                                acc_last,
  output logic                                                result_valid,
  output logic                                                busy,
  output logic                                                overrun
);

  localparam int unsigned TAP_LEN = DECIMATION_FACTOR * SUB_TAP_LEN;
  localparam int unsigned CAW     = $clog2(TAP_LEN);
  localparam int unsigned PW      = $clog2(DECIMATION_FACTOR + 1);
  localparam int unsigned JW      = $clog2(SUB_TAP_LEN + 1);
  localparam int unsigned DW      = $clog2(MAC_LATENCY + 1);

  // The buffer must hold the active burst's window plus one full pending frame.
  if ((2 ** BUF_AW) < (2 * TAP_LEN)) begin : g_buf_chk
    $error("poly_fir_mac_sched: 2**BUF_AW must be >= 2*TAP_LEN");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [BUF_AW-1:0]      wr_q, wr_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [PW-1:0]          p_q, p_d;
  logic [JW-1:0]          j_q, j_d;
  logic [BUF_AW-1:0]      base_q, base_d;
  logic                   pend_q, pend_d;
  logic [BUF_AW-1:0]      pbase_q, pbase_d;
  logic                   ovr_q, ovr_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic                   mac_en_q, mac_en_d;
  logic                   acc_clr_q, acc_clr_d;
  logic                   acc_last_q, acc_last_d;
  logic [CAW-1:0]         coef_q, coef_d;
  logic [BUF_AW-1:0]      raddr_q, raddr_d;
  logic [MAC_LATENCY-1:0] dl_q, dl_d;
  logic                   busy_q, busy_d;

  logic                   phase_last;
  logic                   trig;
  logic                   last_issue;
  logic                   start;
  logic                   issue;
  logic [CAW-1:0]         n_d;

  assign phase_last = (phase_q == PW'(DECIMATION_FACTOR - 1));
  assign trig       = din_valid & ~flush & phase_last;
  assign last_issue = (state_q == S_RUN) & (p_q == PW'(DECIMATION_FACTOR - 1)) &
                      (j_q == JW'(SUB_TAP_LEN - 1));

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_q       <= '0;
      phase_q    <= '0;
      p_q        <= '0;
      j_q        <= '0;
      base_q     <= '0;
      pend_q     <= 1'b0;
      pbase_q    <= '0;
      ovr_q      <= 1'b0;
      drain_q    <= '0;
      mac_en_q   <= 1'b0;
      acc_clr_q  <= 1'b0;
      acc_last_q <= 1'b0;
      coef_q     <= '0;
      raddr_q    <= '0;
      dl_q       <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      phase_q    <= phase_d;
      p_q        <= p_d;
      j_q        <= j_d;
      base_q     <= base_d;
      pend_q     <= pend_d;
      pbase_q    <= pbase_d;
      ovr_q      <= ovr_d;
      drain_q    <= drain_d;
      mac_en_q   <= mac_en_d;
      acc_clr_q  <= acc_clr_d;
      acc_last_q <= acc_last_d;
      coef_q     <= coef_d;
      raddr_q    <= raddr_d;
      dl_q       <= dl_d;
      busy_q     <= busy_d;
    end
  end

  // Next state: write pointer, phase, burst counters and one-deep pending frame
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    phase_d = phase_q;
    p_d     = p_q;
    j_d     = j_q;
    base_d  = base_q;
    pend_d  = pend_q;
    pbase_d = pbase_q;
    ovr_d   = ovr_q;
    drain_d = drain_q;
    start   = 1'b0;

    if (din_valid) begin
      wr_d    = wr_q + BUF_AW'(1);
      phase_d = phase_last ? '0 : phase_q + PW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          start  = 1'b1;
          base_d = pbase_q;
          pend_d = 1'b0;
        end else if (trig) begin
          start  = 1'b1;
          base_d = wr_q;
        end
      end
      S_RUN: begin
        if (last_issue) begin
          if (pend_q) begin
            start  = 1'b1;
            base_d = pbase_q;
            pend_d = 1'b0;
            if (trig) ovr_d = 1'b1;
          end else if (trig) begin
            start  = 1'b1;
            base_d = wr_q;
          end else begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end else begin
          if (j_q == JW'(SUB_TAP_LEN - 1)) begin
            j_d = '0;
            p_d = p_q + PW'(1);
          end else begin
            j_d = j_q + JW'(1);
          end
          if (trig) begin
            if (pend_q) begin
              ovr_d = 1'b1;
            end else begin
              pend_d  = 1'b1;
              pbase_d = wr_q;
            end
          end
        end
      end
      S_DRAIN: begin
        if (trig) begin
          start  = 1'b1;
          base_d = wr_q;
        end else if (drain_q == DW'(MAC_LATENCY - 1)) begin
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d = S_RUN;
      p_d     = '0;
      j_d     = '0;
    end

    if (flush) begin
      state_d = S_IDLE;
      wr_d    = '0;
      phase_d = '0;
      p_d     = '0;
      j_d     = '0;
      base_d  = '0;
      pend_d  = 1'b0;
      pbase_d = '0;
      ovr_d   = 1'b0;
      drain_d = '0;
    end
  end

  // Issue outputs for the next cycle; tap n = j*D + p reads the sample n inputs older
  always_comb begin
    issue      = (state_d == S_RUN);
    n_d        = CAW'(32'(j_d) * DECIMATION_FACTOR + 32'(p_d));
    mac_en_d   = issue;
    acc_clr_d  = issue & (p_d == '0) & (j_d == '0);
    acc_last_d = issue & (p_d == PW'(DECIMATION_FACTOR - 1)) & (j_d == JW'(SUB_TAP_LEN - 1));
    coef_d     = issue ? n_d : '0;
    raddr_d    = issue ? (base_d - BUF_AW'(n_d)) : '0;
    dl_d       = (dl_q << 1) | MAC_LATENCY'(acc_last_q);
    if (flush) dl_d = '0;
    busy_d     = (state_d != S_IDLE) | (|dl_d);
  end

  assign smp_we       = din_valid & ~flush & rst_n;
  assign smp_waddr    = wr_q;
  assign smp_raddr    = raddr_q;
  assign coef_addr    = coef_q;
  assign mac_en       = mac_en_q;
  assign acc_clr      = acc_clr_q;
  assign acc_last     = acc_last_q;
  assign result_valid = dl_q[MAC_LATENCY-1];
  assign busy         = busy_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_poly_fir_mac_sched.sv
// Bench for poly_fir_mac_sched: burst-schedule reference model plus a small MAC datapath
// model for the impulse-response check.
module tb_poly_fir_mac_sched;

  localparam int D = 9;
  localparam int S = 7;
  localparam int T = D * S;
  localparam int NEVER = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       rst_n, flush, din_valid;
  logic       smp_we, mac_en, acc_clr, acc_last, result_valid, busy, overrun;
  logic [6:0] smp_waddr, smp_raddr;
  logic [5:0] coef_addr;

  poly_fir_mac_sched dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din_valid(din_valid),
    .smp_we(smp_we), .smp_waddr(smp_waddr), .smp_raddr(smp_raddr), .coef_addr(coef_addr),
    .mac_en(mac_en), .acc_clr(acc_clr), .acc_last(acc_last), .result_valid(result_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  wire [26:0] obs_vec = {smp_we, smp_waddr, smp_raddr, coef_addr, mac_en, acc_clr,
                         acc_last, result_valid, busy, overrun};

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [26:0] exp_vec;

  // Reference model: list of scheduled bursts (start cycle, base address, abort cycle)
  int bst[$];
  int bbase[$];
  int bcut[$];
  int m_wr, m_ph;
  logic m_ovr;

  // Datapath model: sample RAM, coefficient ROM, two-stage MAC
  logic signed [15:0] ram [0:127];
  logic signed [15:0] coef [0:T-1];
  logic signed [15:0] din_data;
  logic               ram_clr;
  longint             prod_q, acc;
  logic               v_q, clr_q;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 128; i++) ram[i] <= '0;
    end else if (smp_we) begin
      ram[smp_waddr] <= din_data;
    end
    prod_q <= longint'(ram[smp_raddr]) * longint'(coef[coef_addr]);
    v_q    <= mac_en;
    clr_q  <= acc_clr;
    if (v_q) acc <= clr_q ? prod_q : acc + prod_q;
  end

  task automatic model_reset();
    bst.delete(); bbase.delete(); bcut.delete();
    m_wr = 0; m_ph = 0; m_ovr = 1'b0;
  endtask

  task automatic model_expect(input logic dv, input logic fl);
    logic mac, clr, lst, rv, bz;
    logic [5:0] ca;
    logic [6:0] ra;
    int k, n;
    mac = 0; clr = 0; lst = 0; rv = 0; bz = 0; ca = '0; ra = '0;
    for (int i = 0; i < bst.size(); i++) begin
      k = cyc - bst[i];
      if (cyc <= bcut[i] && k >= 0 && k <= T + 1) begin
        bz = 1'b1;
        if (k < T) begin
          n   = (k % S) * D + k / S;
          mac = 1'b1; clr = (k == 0); lst = (k == T - 1);
          ca  = 6'(n);
          ra  = 7'((bbase[i] - n) & 127);
        end
        if (k == T + 1) rv = 1'b1;
      end
    end
    exp_vec = {dv & ~fl, 7'(m_wr), ra, ca, mac, clr, lst, rv, bz, m_ovr};
  endtask

  task automatic model_update(input logic dv, input logic fl);
    int last, waiting;
    if (fl) begin
      for (int i = 0; i < bcut.size(); i++) if (bcut[i] > cyc) bcut[i] = cyc;
      m_wr = 0; m_ph = 0; m_ovr = 1'b0;
    end else if (dv) begin
      if (m_ph == D - 1) begin
        last = -1000; waiting = 0;
        for (int i = 0; i < bst.size(); i++) begin
          if (bcut[i] == NEVER) begin
            if (bst[i] + T - 1 > last) last = bst[i] + T - 1;
            if (bst[i] > cyc) waiting++;
          end
        end
        if (last < cyc) begin
          bst.push_back(cyc + 1); bbase.push_back(m_wr); bcut.push_back(NEVER);
        end else if (waiting == 0) begin
          bst.push_back(last + 1); bbase.push_back(m_wr); bcut.push_back(NEVER);
        end else begin
          m_ovr = 1'b1;
        end
      end
      m_wr = (m_wr + 1) % 128;
      m_ph = (m_ph + 1) % D;
    end
    while (bst.size() > 0 && (bst[0] + T + 1 < cyc || bcut[0] < cyc)) begin
      void'(bst.pop_front()); void'(bbase.pop_front()); void'(bcut.pop_front());
    end
  endtask

  // One clock: expectations for this cycle, then drive inputs and advance the model
  task automatic drive(input logic dv, input logic fl, input logic signed [15:0] data);
    @(posedge clk); #1;
    cyc++;
    model_expect(dv, fl);
    din_valid = dv; flush = fl; din_data = data;
    #1;
    model_update(dv, fl);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 25; k++) begin
      drive(k < 9, 1'b0, 16'sd0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL reset_pre k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
    @(negedge clk);
    rst_n = 1'b0; din_valid = 1'b1;
    #1;
    n_vec++;
    if (obs_vec !== 27'd0) begin
      n_bad++; $display("FAIL reset_async got=%h exp=%h", obs_vec, 27'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; din_valid = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 16'sd0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL reset_post k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single_frame();
    int first_k, rv_k, mac_cnt, rv_cnt;
    logic [6:0] first_ra, last_ra;
    first_k = -1; rv_k = -1; mac_cnt = 0; rv_cnt = 0; first_ra = '0; last_ra = '0;
    for (int k = 0; k < 150; k++) begin
      drive((k % 8 == 0) && (k <= 64), 1'b0, 16'sd0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL single_frame k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      if (mac_en) begin
        if (first_k < 0) begin first_k = k; first_ra = smp_raddr; end
        last_ra = smp_raddr; mac_cnt++;
      end
      if (result_valid) begin rv_k = k; rv_cnt++; end
    end
    n_vec++;
    if (first_k !== 65 || mac_cnt !== T) begin
      n_bad++; $display("FAIL single_window first=%0d cnt=%0d exp first=65 cnt=63", first_k, mac_cnt);
    end
    n_vec++;
    if (first_ra !== 7'd8 || last_ra !== 7'd74) begin
      n_bad++; $display("FAIL single_raddr first=%0d last=%0d exp 8/74", first_ra, last_ra);
    end
    n_vec++;
    if (rv_k !== 129 || rv_cnt !== 1) begin
      n_bad++; $display("FAIL single_result k=%0d cnt=%0d exp k=129 cnt=1", rv_k, rv_cnt);
    end
  endtask

  task automatic test_golden();
    int m;
    longint y, ye;
    m = 0;
    ram_clr = 1'b1;
    drive(1'b0, 1'b1, 16'sd0);
    ram_clr = 1'b0;
    for (int k = 0; k < 8 * 72 + 70; k++) begin
      drive((k % 8 == 0) && (k < 8 * 72), 1'b0, (k == 64) ? 16'sh7fff : 16'sd0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL golden_seq k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      if (result_valid) begin
        y  = acc >>> 15;
        ye = (m < S) ? ((longint'(coef[m * D]) * 32767) >>> 15) : 0;
        n_vec++;
        if (y !== ye) begin
          n_bad++; $display("FAIL golden_y m=%0d got=%0d exp=%0d", m, y, ye);
        end
        m++;
      end
    end
    n_vec++;
    if (m !== 8) begin
      n_bad++; $display("FAIL golden_count got=%0d exp=8", m);
    end
  endtask

  task automatic test_full_rate();
    int mac_cnt, clr_cnt, first_k, last_k;
    mac_cnt = 0; clr_cnt = 0; first_k = -1; last_k = -1;
    drive(1'b0, 1'b1, 16'sd0);
    for (int k = 0; k < 200; k++) begin
      drive(k < 27, 1'b0, 16'(k));
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL full_rate k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      if (mac_en) begin
        if (first_k < 0) first_k = k;
        last_k = k; mac_cnt++;
      end
      if (mac_en && acc_clr) clr_cnt++;
    end
    n_vec++;
    if (mac_cnt !== 2 * T || clr_cnt !== 2 || first_k !== 9 || last_k !== 134) begin
      n_bad++; $display("FAIL full_rate_bursts cnt=%0d clr=%0d %0d..%0d exp 126/2 9..134",
                        mac_cnt, clr_cnt, first_k, last_k);
    end
    n_vec++;
    if (overrun !== 1'b1) begin
      n_bad++; $display("FAIL full_rate_overrun got=%b exp=1", overrun);
    end
  endtask

  task automatic test_boundary();
    logic last71, clr72, mac72;
    last71 = 0; clr72 = 0; mac72 = 0;
    drive(1'b0, 1'b1, 16'sd0);
    for (int k = 0; k < 150; k++) begin
      drive((k < 9) || (k >= 63 && k <= 71), 1'b0, 16'sd0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL boundary k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      if (k == 71) last71 = mac_en & acc_last;
      if (k == 72) begin clr72 = acc_clr; mac72 = mac_en; end
    end
    n_vec++;
    if ({last71, mac72, clr72, overrun} !== 4'b1110) begin
      n_bad++; $display("FAIL boundary_b2b got=%b exp=1110", {last71, mac72, clr72, overrun});
    end
  endtask

  task automatic test_flush_pending();
    int rv_after;
    logic ovr30;
    logic [2:0] post;
    rv_after = 0; ovr30 = 0; post = '1;
    drive(1'b0, 1'b1, 16'sd0);
    for (int k = 0; k < 120; k++) begin
      drive(k < 27, k == 30, 16'sd0);
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL flush_pending k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
      if (k == 30) ovr30 = overrun;
      if (k == 31) post = {mac_en, busy, overrun};
      if (k > 30 && result_valid) rv_after++;
    end
    n_vec++;
    if (ovr30 !== 1'b1 || post !== 3'b000 || rv_after !== 0) begin
      n_bad++; $display("FAIL flush_abort ovr=%b post=%b rv=%0d exp 1/000/0", ovr30, post, rv_after);
    end
  endtask

  task automatic test_random();
    int rate;
    logic dv, fl;
    rate = 8;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) rate = 1 + $urandom_range(11);
      dv = ($urandom_range(rate - 1) == 0);
      fl = ($urandom_range(399) == 0);
      drive(dv, fl, 16'($urandom));
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_bad++; $display("FAIL random k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; din_valid = 1'b0; din_data = '0; ram_clr = 1'b0;
    for (int i = 0; i < T; i++) coef[i] = 16'($urandom);
    model_reset();
    #12 rst_n = 1'b1;
    test_reset();
    test_single_frame();
    test_golden();
    test_full_rate();
    test_boundary();
    test_flush_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
